// File: rtl/vga_cmd_sequencer.sv
// Host command FIFO and decoder; sole driver of the vgamult sprite, background and font-write controls.
// Optional build macro VSYNC_DEFER_EN: display updates wait for the synchronized active-low vsync.
module vga_cmd_sequencer #(
    parameter int DEPTH         = 16,
    parameter int STROBE_CYCLES = 1
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    input  logic        vsync,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [4:0]  sprite_sel,
    output logic        visable,
    output logic        load_pos,
    output logic        load_att,
    output logic [1:0]  background_sel,
    output logic        bchange_active,
    output logic [10:0] fwaddr,
    output logic [3:0]  fwdata,
    output logic        fwenable,
    output logic        fchange_active,
    output logic        busy,
    output logic        err
);
    localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT    = (AW + 1)'(DEPTH);
    localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYCLES - 1);

    localparam logic [2:0] OP_POS  = 3'd1;
    localparam logic [2:0] OP_ATT  = 3'd2;
    localparam logic [2:0] OP_BG   = 3'd3;
    localparam logic [2:0] OP_FWR  = 3'd4;
    localparam logic [2:0] OP_FEND = 3'd5;

`ifdef VSYNC_DEFER_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POP      = 3'd1,
        SETUP    = 3'd2,
        STROBE   = 3'd3,
        WAIT_VBL = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3
    } state_t;
`endif

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    state_t        state;
    logic [31:0]   cmd_reg;
    logic [2:0]    op;
    logic [3:0]    strobe_cnt;
    logic          is_disp;
    logic          go_setup;
    logic          unused_ok;

    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign op         = cmd_reg[31:29];
    assign busy       = (count != '0) || (state != IDLE);

`ifdef VSYNC_DEFER_EN
    logic vsync_meta;
    logic vsync_s;

    // Two-flop synchronizer; resets to the inactive (high) level.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            vsync_meta <= 1'b1;
            vsync_s    <= 1'b1;
        end else begin
            vsync_meta <= vsync;
            vsync_s    <= vsync_meta;
        end
    end

    assign unused_ok = cmd_reg[4];
`else
    assign unused_ok = ^{vsync, cmd_reg[4]};
`endif

    always_ff @(posedge clk_100) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    // cmd_ready is registered from the next occupancy, so it stays low through reset.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            cmd_ready <= (count_next != FULL_CNT);
        end
    end

    always_comb begin
        is_disp  = (op == OP_POS) || (op == OP_ATT) || (op == OP_BG);
        go_setup = 1'b0;
`ifdef VSYNC_DEFER_EN
        if (state == POP) begin
            go_setup = (op == OP_FWR);
        end else if (state == WAIT_VBL) begin
            go_setup = ~vsync_s;
        end
`else
        if (state == POP) begin
            go_setup = is_disp || (op == OP_FWR);
        end
`endif
    end

    // Data fields load on the edge entering SETUP; strobes rise one edge later.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            state          <= IDLE;
            cmd_reg        <= '0;
            strobe_cnt     <= '0;
            x              <= '0;
            y              <= '0;
            sprite_sel     <= '0;
            visable        <= 1'b0;
            load_pos       <= 1'b0;
            load_att       <= 1'b0;
            background_sel <= '0;
            bchange_active <= 1'b0;
            fwaddr         <= '0;
            fwdata         <= '0;
            fwenable       <= 1'b0;
            fchange_active <= 1'b0;
            err            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_reg <= mem[rd_ptr];
                        state   <= POP;
                    end
                end
                POP: begin
                    if (go_setup) begin
                        state <= SETUP;
`ifdef VSYNC_DEFER_EN
                    end else if (is_disp) begin
                        state <= WAIT_VBL;
`endif
                    end else begin
                        state <= IDLE;
                        if (op == OP_FEND) begin
                            fchange_active <= 1'b0;
                        end
                        if (op[2:1] == 2'b11) begin
                            err <= 1'b1;
                        end
                    end
                end
`ifdef VSYNC_DEFER_EN
                WAIT_VBL: begin
                    if (go_setup) begin
                        state <= SETUP;
                    end
                end
`endif
                SETUP: begin
                    state          <= STROBE;
                    strobe_cnt     <= STROBE_LAST;
                    load_pos       <= (op == OP_POS);
                    load_att       <= (op == OP_ATT);
                    bchange_active <= (op == OP_BG);
                    fwenable       <= (op == OP_FWR);
                end
                STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        load_pos       <= 1'b0;
                        load_att       <= 1'b0;
                        bchange_active <= 1'b0;
                        fwenable       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (go_setup) begin
                case (op)
                    OP_POS: begin
                        sprite_sel <= cmd_reg[28:24];
                        x          <= cmd_reg[23:14];
                        y          <= cmd_reg[13:5];
                    end
                    OP_ATT: begin
                        sprite_sel <= cmd_reg[28:24];
                        visable    <= cmd_reg[0];
                    end
                    OP_BG: begin
                        background_sel <= cmd_reg[1:0];
                    end
                    OP_FWR: begin
                        fwaddr         <= cmd_reg[26:16];
                        fwdata         <= cmd_reg[3:0];
                        fchange_active <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
